// File: rtl/ksa_pkg.sv
// Shared types, constants and helpers for the RC4 key-scheduling block.
package ksa_pkg;

  // One state per S-memory access slot; six slots per i.
  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StLatI,
    StRdJ,
    StLatJ,
    StWrI,
    StWrJ
  } ksa_state_e;

  localparam logic [7:0]  S_LAST            = 8'd255;
  localparam int unsigned KEY_BYTES_DEFAULT = 3;
  // Widest key the byte-select helper can index.
  localparam int unsigned KEY_BYTES_MAX     = 32;

  // Byte idx of a key holding nbytes bytes, byte 0 in the most significant position.
  // The key is zero-extended to KEY_BYTES_MAX bytes so one helper serves every width.
  function automatic logic [7:0] key_byte_sel(input logic [8*KEY_BYTES_MAX-1:0] key_ext,
                                              input int unsigned              nbytes,
                                              input int unsigned              idx);
    logic [7:0] b;
    b = key_ext[8*(nbytes-1-idx) +: 8];
    return b;
  endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling permutation over a 256-byte single-port S memory with
// one cycle of read latency. Each i takes six cycles: read s[i], update j,
// read s[j], then write the swapped pair back.
module ksa
  import ksa_pkg::*;
#(
  parameter int unsigned KEY_BYTES  = KEY_BYTES_DEFAULT,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int unsigned KidxW    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KidxW-1:0] KidxLast = KidxW'(KEY_BYTES - 1);

  // The state sequence hard-codes a single latency slot after each read.
  if (MEM_RD_LAT != 1) begin : g_bad_lat
    $error("ksa: only MEM_RD_LAT == 1 is supported");
  end
  if (KEY_BYTES < 1 || KEY_BYTES > KEY_BYTES_MAX) begin : g_bad_key
    $error("ksa: KEY_BYTES out of range");
  end

  ksa_state_e       state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [KidxW-1:0] kidx_q, kidx_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;

  logic [8*KEY_BYTES_MAX-1:0] key_ext;
  logic [7:0]                 key_cur;

  assign key_ext = (8*KEY_BYTES_MAX)'(key);
  assign key_cur = key_byte_sel(key_ext, KEY_BYTES, 32'(kidx_q));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  // Next-state and datapath updates; j only moves in StLatI where rddata holds s[i].
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRdI;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      StRdI:  state_d = StLatI;
      StLatI: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_cur;
        state_d = StRdJ;
      end
      StRdJ:  state_d = StLatJ;
      StLatJ: begin
        sj_d    = rddata;
        state_d = StWrI;
      end
      StWrI:  state_d = StWrJ;
      StWrJ: begin
        if (i_q == S_LAST) begin
          state_d = StIdle;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KidxLast) ? '0 : kidx_q + KidxW'(1);
          state_d = StRdI;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory-side outputs decoded straight from state; i==j needs no special case.
  always_comb begin
    rdy    = 1'b0;
    wren   = 1'b0;
    addr   = '0;
    wrdata = '0;
    case (state_q)
      StIdle:        rdy  = 1'b1;
      StRdI, StLatI: addr = i_q;
      StRdJ, StLatJ: addr = j_q;
      StWrI: begin
        addr   = i_q;
        wrdata = sj_q;
        wren   = 1'b1;
      end
      StWrJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural S memory plus a software RC4 KSA model.
module tb_ksa;

  localparam int KB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rdy;
  logic [23:0]   key;
  logic [7:0]    addr;
  logic [7:0]    rddata;
  logic [7:0]    wrdata;
  logic          wren;

  ksa #(.KEY_BYTES(KB), .MEM_RD_LAT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];
  logic [7:0] rd_pipe;
  logic [7:0] ref_s [256];
  logic [7:0] exp_wa [512];
  logic [7:0] exp_wd [512];
  logic [7:0] wa [$];
  logic [7:0] wd [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; the memory acts on what the DUT drove during the
  // cycle just ended and presents that read in the following cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    rddata  = rd_pipe;
    rd_pipe = mem[addr];
    if (wren) begin
      mem[addr] = wrdata;
      wa.push_back(addr);
      wd.push_back(wrdata);
    end
  endtask

  task automatic mem_init();
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
  endtask

  task automatic ref_init();
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
  endtask

  // Plain software KSA on ref_s, also listing the writes a swap-based
  // implementation makes: s[i] <- old s[j], then s[j] <- old s[i].
  task automatic ref_ksa(input logic [23:0] k);
    int j;
    int kb;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = int'((k >> (8 * (KB - 1 - (i % KB)))) & 24'hFF);
      j = (j + int'(ref_s[i]) + kb) % 256;
      exp_wa[2*i]   = 8'(i);
      exp_wd[2*i]   = ref_s[j];
      exp_wa[2*i+1] = 8'(j);
      exp_wd[2*i+1] = ref_s[i];
      t        = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) bad++;
    check_eq(tag, bad, 0);
  endtask

  // Runs one pass. start=1 pulses en from idle; start=0 assumes the DUT has
  // just entered its first read. rst_at >= 0 aborts with a reset at that cycle.
  task automatic run_ksa(input logic [23:0] k, input bit start, input bit hold_en,
                         input int rst_at);
    int cycles;
    int phase_err;
    int bad;
    int nw;
    key = k;
    wa.delete();
    wd.delete();
    if (start) begin
      en = 1'b1;
      tick();
    end
    cycles    = -1;
    phase_err = 0;
    for (int n = 0; n < 2000; n++) begin
      if (rdy) begin
        cycles = n;
        break;
      end
      if (wren !== ((n % 6) >= 4)) phase_err++;
      if (n == rst_at) begin
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rst_rdy", rdy, 1);
        check_eq("rst_wren", wren, 0);
        nw = wa.size();
        repeat (20) tick();
        check_eq("rst_no_writes", wa.size() - nw, 0);
        check_eq("rst_phase", phase_err, 0);
        return;
      end
      en = hold_en ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    if (!hold_en) en = 1'b0;
    check_eq("run_cycles", cycles, 1536);
    check_eq("wren_phase", phase_err, 0);
    check_eq("write_count", wa.size(), 512);
    bad = 0;
    for (int w = 0; w < 512 && w < wa.size(); w++)
      if (wa[w] !== exp_wa[w] || wd[w] !== exp_wd[w]) bad++;
    check_eq("write_log", bad, 0);
  endtask

  initial begin
    logic [23:0] k;
    logic [7:0]  e_a [6];
    logic [7:0]  e_d [6];
    e_a = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    e_d = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};

    rst     = 1'b1;
    en      = 1'b0;
    key     = '0;
    rddata  = '0;
    rd_pipe = '0;
    mem_init();
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("idle_rdy", rdy, 1);
      check_eq("idle_wren", wren, 0);
      check_eq("idle_addr", addr, 0);
      check_eq("idle_wrdata", wrdata, 0);
    end

    // All-zero key on identity memory, first writes checked by hand.
    mem_init();
    ref_init();
    ref_ksa(24'h000000);
    run_ksa(24'h000000, 1'b1, 1'b0, -1);
    if (wa.size() >= 6) begin
      for (int w = 0; w < 6; w++) begin
        check_eq("zero_key_waddr", wa[w], e_a[w]);
        check_eq("zero_key_wdata", wd[w], e_d[w]);
      end
    end else begin
      check_eq("zero_key_first_writes", wa.size(), 6);
    end
    check_mem("zero_key_final_s");

    // Fixed key, then random keys.
    for (int r = 0; r < 4; r++) begin
      k = (r == 0) ? 24'h00033C : 24'($urandom);
      mem_init();
      ref_init();
      ref_ksa(k);
      run_ksa(k, 1'b1, 1'b0, -1);
      check_mem("final_s");
    end

    // Reset mid-run, then a clean rerun from a fresh identity.
    k = 24'($urandom);
    mem_init();
    ref_init();
    ref_ksa(k);
    run_ksa(k, 1'b1, 1'b0, 700);
    mem_init();
    run_ksa(k, 1'b1, 1'b0, -1);
    check_mem("after_rst_final_s");

    // en held high across completion: one idle cycle, then a second pass.
    k = 24'($urandom);
    mem_init();
    ref_init();
    ref_ksa(k);
    run_ksa(k, 1'b1, 1'b1, -1);
    check_mem("held_en_first_s");
    tick();
    check_eq("restart_rdy", rdy, 0);
    check_eq("restart_addr", addr, 0);
    check_eq("restart_wren", wren, 0);
    en = 1'b0;
    ref_ksa(k);
    run_ksa(k, 1'b0, 1'b0, -1);
    check_mem("held_en_second_s");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
